shot_param_ctrl: RTL

//  Player-input front end for the artillery game: debounces four raw buttons, holds angle/power settings,
//  and runs the aim/fire handshake with game logic. Drives the 7-seg display driver directly upstream:

---
 rtl/shot_param_ctrl_pkg.sv | 29 ++
 rtl/shot_param_ctrl_btn_debounce.sv | 50 +++++
 rtl/shot_param_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/shot_param_ctrl_pkg.sv
// Shared definitions for the shot parameter controller: FSM state encoding,
// angle step size and small arithmetic helpers.
package shot_param_ctrl_pkg;

   typedef enum logic [1:0] {
      StAdjAngle = 2'd0,
      StAdjPower = 2'd1,
      StFired    = 2'd2
   } state_e;

   // Degrees per angle index step (index 15 -> 90 degrees).
   localparam int unsigned ANGLE_STEP_DEG = 6;

   // One saturating step of a 4-bit field; up and down together cancel.
   function automatic logic [3:0] step_field(input logic [3:0] v, input logic up,
                                             input logic dn, input logic [3:0] vmax);
      if (up && !dn && (v < vmax)) return v + 4'd1;
      if (dn && !up && (v != 4'd0)) return v - 4'd1;
      return v;
   endfunction

   // Display word: angle in degrees times 100 plus power (max 9015).
   function automatic logic [15:0] disp_value(input logic [3:0] angle, input logic [3:0] power);
      logic [6:0] deg;
      deg = 7'(angle) * 7'(ANGLE_STEP_DEG);
      return (16'(deg) * 16'd100) + 16'(power);
   endfunction

endpackage

// File: rtl/shot_param_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a registered
// one-cycle press event on the rising edge of the debounced level.
module shot_param_ctrl_btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1, sync2;
   logic [CW-1:0] cnt;

   // Two-stage synchronizer for the asynchronous button input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Count consecutive cycles the synced input disagrees with the level; any agreement restarts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else if (sync2 != level) begin
         if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync2;
            press <= sync2;
         end else begin
            cnt   <= cnt + 1'b1;
            press <= 1'b0;
         end
      end else begin
         cnt   <= '0;
         press <= 1'b0;
      end
   end

endmodule

// File: rtl/shot_param_ctrl.sv
// Player-input front end: debounced buttons, angle/power fields, aim/fire
// handshake and the display word. Optional feature macro: AUTO_REPEAT_EN
// (held up/down auto-repeat); the default build has exactly one step per press.
module shot_param_ctrl
   import shot_param_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned ANGLE_MAX       = 15,
   parameter int unsigned POWER_MAX       = 15,
   parameter int unsigned HOLD_CYCLES     = 50000000,
   parameter int unsigned REPEAT_CYCLES   = 10000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_mode,
   input  logic        btn_fire,
   input  logic        shot_done,
   output logic [3:0]  angle_out,
   output logic [3:0]  power_out,
   output logic        sel_power,
   output logic        shot_fire,
   output logic        busy,
   output logic [15:0] display_number
);

   logic   up_lvl, up_prs, dn_lvl, dn_prs, mode_lvl, mode_prs, fire_lvl, fire_prs;
   logic   up_ev, dn_ev;
   logic   unused_levels;
   state_e state, ret_state;

   shot_param_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk(clk), .rst_n(rst_n), .raw(btn_up), .level(up_lvl), .press(up_prs));
   shot_param_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .clk(clk), .rst_n(rst_n), .raw(btn_down), .level(dn_lvl), .press(dn_prs));
   shot_param_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk(clk), .rst_n(rst_n), .raw(btn_mode), .level(mode_lvl), .press(mode_prs));
   shot_param_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
      .clk(clk), .rst_n(rst_n), .raw(btn_fire), .level(fire_lvl), .press(fire_prs));

   assign unused_levels = ^{up_lvl, dn_lvl, mode_lvl, fire_lvl};

`ifdef AUTO_REPEAT_EN
   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

   logic [HW-1:0] hold_cnt;
   logic          held, rep;

   // Exactly one of up/down held while adjusting; a mode press also restarts the hold.
   assign held = (up_lvl ^ dn_lvl) && (state != StFired) && !mode_prs;
   assign rep  = held && (hold_cnt == HW'(HOLD_CYCLES - 1));

   // Hold timer: first step after HOLD_CYCLES, then reload so later steps come every REPEAT_CYCLES.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if (!held) begin
         hold_cnt <= '0;
      end else if (rep) begin
         hold_cnt <= HW'(HOLD_CYCLES - REPEAT_CYCLES);
      end else begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

   assign up_ev = up_prs | (rep & up_lvl);
   assign dn_ev = dn_prs | (rep & dn_lvl);
`else
   localparam int unsigned unused_repeat_cfg = HOLD_CYCLES + REPEAT_CYCLES;

   assign up_ev = up_prs;
   assign dn_ev = dn_prs;
`endif

   // Aim/fire FSM with registered field and handshake outputs; fire > mode > up/down.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StAdjAngle;
         ret_state <= StAdjAngle;
         angle_out <= 4'd0;
         power_out <= 4'd0;
         sel_power <= 1'b0;
         shot_fire <= 1'b0;
         busy      <= 1'b0;
      end else begin
         shot_fire <= 1'b0;
         unique case (state)
            StAdjAngle, StAdjPower: begin
               if (fire_prs) begin
                  if (power_out != 4'd0) begin
                     shot_fire <= 1'b1;
                     busy      <= 1'b1;
                     ret_state <= state;
                     state     <= StFired;
                  end
               end else if (mode_prs) begin
                  state     <= (state == StAdjAngle) ? StAdjPower : StAdjAngle;
                  sel_power <= (state == StAdjAngle);
               end else if (state == StAdjPower) begin
                  power_out <= step_field(power_out, up_ev, dn_ev, 4'(POWER_MAX));
               end else begin
                  angle_out <= step_field(angle_out, up_ev, dn_ev, 4'(ANGLE_MAX));
               end
            end
            StFired: begin
               // A shot_done coincident with the launch pulse belongs to no shot of ours.
               if (shot_done && !shot_fire) begin
                  state <= ret_state;
                  busy  <= 1'b0;
               end
            end
            default: state <= StAdjAngle;
         endcase
      end
   end

   // Display word registered from the already-registered field values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         display_number <= 16'd0;
      end else begin
         display_number <= disp_value(angle_out, power_out);
      end
   end

endmodule
